// File: rtl/reset_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - seq_state_e : sequencer FSM states
//   - MAX_STAGES  : upper bound on the number of sequenced domains
//   - IDX_W       : width of a stage index (wide enough for MAX_STAGES)
//   - clog2/max_int : constant helpers used to size the shared timer
// -----------------------------------------------------------------------------
package reset_seq_pkg;

   localparam int MAX_STAGES = 8;
   localparam int IDX_W      = 3;

   typedef enum logic [1:0] {
      S_HOLD  = 2'd0,
      S_WAIT  = 2'd1,
      S_RUN   = 2'd2,
      S_FAULT = 2'd3
   } seq_state_e;

   // Smallest r with 2**r >= value.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// reset_sequencer_if
// Groups the per-domain reset/acknowledge lines and the status outputs of the
// reset sequencer.
//   softResetReq : request to re-run the sequence (into the sequencer)
//   stageReady   : per-domain "out of reset and operational" (into sequencer)
//   domainReset  : per-domain active-high reset (out of sequencer)
//   sysReady     : all domains released and ready
//   busy         : sequence in progress
//   fault        : sticky error flag
//   faultStage   : index of the stage that caused the fault
// master = the sequencer, slave = the domains / system side.
// -----------------------------------------------------------------------------
interface reset_sequencer_if #(
   parameter int NUM_STAGES = 4
);
   logic                  softResetReq;
   logic [NUM_STAGES-1:0] stageReady;
   logic [NUM_STAGES-1:0] domainReset;
   logic                  sysReady;
   logic                  busy;
   logic                  fault;
   logic [2:0]            faultStage;

   modport master (
      input  softResetReq,
      input  stageReady,
      output domainReset,
      output sysReady,
      output busy,
      output fault,
      output faultStage
   );

   modport slave (
      output softResetReq,
      output stageReady,
      input  domainReset,
      input  sysReady,
      input  busy,
      input  fault,
      input  faultStage
   );
endinterface

// File: rtl/reset_sequencer_rs_timer.sv
// -----------------------------------------------------------------------------
// rs_timer
// Up-counter shared by the hold and the ready-timeout checks.
//   clock, reset : system clock, synchronous active-high reset
//   clr          : synchronous clear (wins over en)
//   en           : count enable
//   limit        : runtime terminal count
//   match        : count == limit
// The counter stops at limit, so it can never wrap even if the controller
// keeps enabling it.
// -----------------------------------------------------------------------------
module rs_timer #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] limit,
   output logic         match
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   assign match = (count_q == limit);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && !match) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
// Takes the system reset and releases NUM_STAGES downstream domain resets one
// at a time: all domains are held for HOLD_CYCLES, then stage 0 is released,
// and each further stage is released only after the previous one reports
// ready. A stage that does not come up within TIMEOUT_CYCLES, or a ready line
// that drops once the system is running, puts every domain back in reset and
// raises a sticky fault until reset or softResetReq.
//   clock, reset : system clock, synchronous active-high reset
//   bus (master) : softResetReq/stageReady in; domainReset, sysReady, busy,
//                  fault, faultStage out (all registered)
// -----------------------------------------------------------------------------
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES     = 4,
   parameter int HOLD_CYCLES    = 3,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clock,
   input  logic              reset,
   reset_sequencer_if.master bus
);

   localparam int CNT_W = clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LIM  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

   seq_state_e            state_q, state_d;
   logic [IDX_W-1:0]      stage_q, stage_d;
   logic [NUM_STAGES-1:0] domain_reset_q, domain_reset_d;
   logic                  sys_ready_q, sys_ready_d;
   logic                  busy_q, busy_d;
   logic                  fault_q, fault_d;
   logic [IDX_W-1:0]      fault_stage_q, fault_stage_d;

   logic                  tmr_clr;
   logic                  tmr_en;
   logic                  tmr_match;
   logic [CNT_W-1:0]      tmr_limit;

   logic [NUM_STAGES-1:0] cur_sel;     // ready bit of the current stage only
   logic [NUM_STAGES-1:0] next_rel;    // one-hot of the stage released next
   logic                  cur_ready;
   logic [IDX_W-1:0]      low_zero;    // lowest-index stage not ready

   // Decode the current stage index against each domain so that readiness
   // of stages other than the current one never reaches the FSM.
   for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
      assign cur_sel[gi]  = (stage_q == IDX_W'(gi)) & bus.stageReady[gi];
      assign next_rel[gi] = ((stage_q + IDX_W'(1)) == IDX_W'(gi));
   end

   assign cur_ready = |cur_sel;

   always_comb begin
      low_zero = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         if (!bus.stageReady[i]) begin
            low_zero = IDX_W'(i);
         end
      end
   end

   rs_timer #(
      .W (CNT_W)
   ) u_timer (
      .clock (clock),
      .reset (reset),
      .clr   (tmr_clr),
      .en    (tmr_en),
      .limit (tmr_limit),
      .match (tmr_match)
   );

   always_comb begin
      state_d        = state_q;
      stage_d        = stage_q;
      domain_reset_d = domain_reset_q;
      sys_ready_d    = sys_ready_q;
      busy_d         = busy_q;
      fault_d        = fault_q;
      fault_stage_d  = fault_stage_q;
      tmr_clr        = 1'b0;
      tmr_en         = 1'b0;
      tmr_limit      = (state_q == S_HOLD) ? HOLD_LIM : TMO_LIM;

      if (bus.softResetReq) begin
         state_d        = S_HOLD;
         stage_d        = '0;
         domain_reset_d = '1;
         sys_ready_d    = 1'b0;
         busy_d         = 1'b1;
         fault_d        = 1'b0;
         fault_stage_d  = '0;
         tmr_clr        = 1'b1;
      end else begin
         case (state_q)
            S_HOLD: begin
               if (tmr_match) begin
                  domain_reset_d[0] = 1'b0;
                  state_d           = S_WAIT;
                  tmr_clr           = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            S_WAIT: begin
               // Ready is tested before the timeout so a late ack still wins.
               if (cur_ready) begin
                  if (stage_q == LAST_IDX) begin
                     state_d     = S_RUN;
                     sys_ready_d = 1'b1;
                     busy_d      = 1'b0;
                  end else begin
                     stage_d        = stage_q + IDX_W'(1);
                     domain_reset_d = domain_reset_q & ~next_rel;
                  end
                  tmr_clr = 1'b1;
               end else if (tmr_match) begin
                  state_d        = S_FAULT;
                  fault_d        = 1'b1;
                  fault_stage_d  = stage_q;
                  domain_reset_d = '1;
                  busy_d         = 1'b0;
                  tmr_clr        = 1'b1;
               end else begin
                  tmr_en = 1'b1;
               end
            end
            S_RUN: begin
               if (!(&bus.stageReady)) begin
                  state_d        = S_FAULT;
                  fault_d        = 1'b1;
                  fault_stage_d  = low_zero;
                  sys_ready_d    = 1'b0;
                  domain_reset_d = '1;
                  tmr_clr        = 1'b1;
               end
            end
            S_FAULT: begin
               // Terminal until reset or softResetReq.
            end
            default: begin
               state_d = S_FAULT;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= S_HOLD;
         stage_q        <= '0;
         domain_reset_q <= '1;
         sys_ready_q    <= 1'b0;
         busy_q         <= 1'b1;
         fault_q        <= 1'b0;
         fault_stage_q  <= '0;
      end else begin
         state_q        <= state_d;
         stage_q        <= stage_d;
         domain_reset_q <= domain_reset_d;
         sys_ready_q    <= sys_ready_d;
         busy_q         <= busy_d;
         fault_q        <= fault_d;
         fault_stage_q  <= fault_stage_d;
      end
   end

   assign bus.domainReset = domain_reset_q;
   assign bus.sysReady    = sys_ready_q;
   assign bus.busy        = busy_q;
   assign bus.fault       = fault_q;
   assign bus.faultStage  = fault_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
// Bench for reset_sequencer (NUM_STAGES=4, HOLD_CYCLES=3, TIMEOUT_CYCLES=8).
// Each scenario pushes the output changes it expects (edge number relative to
// the reset edge plus all output values) onto a queue; a negedge monitor pops
// an entry every time the outputs change and compares it. Domains acknowledge
// automatically 2 cycles after their reset falls unless blocked.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int NS = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;
   int base   = 0;

   reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

   reset_sequencer #(
      .NUM_STAGES     (NS),
      .HOLD_CYCLES    (3),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clock = ~clock;

   always @(posedge clock) edge_n <= edge_n + 1;

   typedef struct {
      int         edge_no;
      logic [3:0] dr;
      logic       sr;
      logic       bz;
      logic       ft;
      logic [2:0] fs;
   } ev_t;

   ev_t exp_q[$];
   ev_t ev_m;

   logic       mon_en    = 1'b0;
   logic       mon_armed = 1'b0;
   logic [3:0] p_dr;
   logic       p_sr, p_bz, p_ft;
   logic [2:0] p_fs;
   logic       thermo_ok;
   logic [3:0] thermo;

   logic [NS-1:0] block;
   int            low_cnt [NS];

   // Output-change monitor and thermometer invariant.
   always @(negedge clock) begin
      if (!mon_en || !mon_armed) begin
         p_dr = bus.domainReset; p_sr = bus.sysReady; p_bz = bus.busy;
         p_ft = bus.fault;       p_fs = bus.faultStage;
         mon_armed = mon_en;
      end else begin
         thermo_ok = (bus.domainReset === 4'hF);
         for (int k = 0; k < NS; k++) begin
            thermo = 4'hF;
            thermo = thermo << (k + 1);
            if (bus.domainReset === thermo) thermo_ok = 1'b1;
         end
         checks++;
         if (!thermo_ok) begin
            errors++;
            $display("FAIL thermometer edge %0d domainReset=%b is not thermometer-shaped",
                     edge_n - base, bus.domainReset);
         end
         if (bus.domainReset !== p_dr || bus.sysReady !== p_sr || bus.busy !== p_bz ||
             bus.fault !== p_ft || bus.faultStage !== p_fs) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_change edge %0d dr=%b sysReady=%b busy=%b fault=%b faultStage=%0d",
                        edge_n - base, bus.domainReset, bus.sysReady, bus.busy, bus.fault, bus.faultStage);
            end else begin
               ev_m = exp_q.pop_front();
               if (ev_m.edge_no !== edge_n || ev_m.dr !== bus.domainReset || ev_m.sr !== bus.sysReady ||
                   ev_m.bz !== bus.busy || ev_m.ft !== bus.fault || ev_m.fs !== bus.faultStage) begin
                  errors++;
                  $display("FAIL output_event got edge %0d dr=%b sr=%b busy=%b fault=%b fs=%0d, expected edge %0d dr=%b sr=%b busy=%b fault=%b fs=%0d",
                           edge_n - base, bus.domainReset, bus.sysReady, bus.busy, bus.fault, bus.faultStage,
                           ev_m.edge_no - base, ev_m.dr, ev_m.sr, ev_m.bz, ev_m.ft, ev_m.fs);
               end
            end
            p_dr = bus.domainReset; p_sr = bus.sysReady; p_bz = bus.busy;
            p_ft = bus.fault;       p_fs = bus.faultStage;
         end
      end
   end

   task automatic push_ev(input int rel, input logic [3:0] dr, input logic sr,
                          input logic bz, input logic ft, input logic [2:0] fs);
      ev_t e;
      e.edge_no = base + rel; e.dr = dr; e.sr = sr; e.bz = bz; e.ft = ft; e.fs = fs;
      exp_q.push_back(e);
   endtask

   // Normal release schedule with acks 2 cycles after each release.
   task automatic push_seq();
      push_ev(3,  4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(6,  4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(9,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(12, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(15, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
   endtask

   // One clock, then drive inputs 1 time unit after the edge. Unblocked
   // domains acknowledge 2 cycles after their reset is seen low.
   task automatic tick();
      @(posedge clock);
      #1;
      for (int s = 0; s < NS; s++) begin
         if (bus.domainReset[s]) begin
            low_cnt[s]        = 0;
            bus.stageReady[s] = 1'b0;
         end else begin
            low_cnt[s]++;
            if (!block[s] && low_cnt[s] >= 3) bus.stageReady[s] = 1'b1;
         end
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset(input logic with_soft);
      mon_en           = 1'b0;
      block            = '0;
      bus.stageReady   = '0;
      reset            = 1'b1;
      bus.softResetReq = with_soft;
      tick();
      base = edge_n;
      checks++;
      if (bus.domainReset !== 4'hF) begin
         errors++; $display("FAIL reset_domainReset got %b expected 1111", bus.domainReset);
      end
      checks++;
      if (bus.sysReady !== 1'b0) begin
         errors++; $display("FAIL reset_sysReady got %b expected 0", bus.sysReady);
      end
      checks++;
      if (bus.busy !== 1'b1) begin
         errors++; $display("FAIL reset_busy got %b expected 1", bus.busy);
      end
      checks++;
      if (bus.fault !== 1'b0 || bus.faultStage !== 3'd0) begin
         errors++; $display("FAIL reset_fault got fault=%b fs=%0d expected 0/0", bus.fault, bus.faultStage);
      end
      reset            = 1'b0;
      bus.softResetReq = 1'b0;
      mon_en           = 1'b1;
   endtask

   task automatic finish_test(input string name);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_pending %0d expected output events did not occur (next at edge %0d)",
                  name, exp_q.size(), exp_q[0].edge_no - base);
      end
      exp_q.delete();
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      run(2);
      checks++;
      if (bus.domainReset !== 4'hF || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL hold_edge2 got dr=%b busy=%b expected 1111/1", bus.domainReset, bus.busy);
      end
      finish_test("reset");
      $display("test_reset done");
   endtask

   task automatic test_sequence();
      do_reset(1'b0);
      push_seq();
      run(20);
      finish_test("sequence");
      checks++;
      if (bus.sysReady !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL sequence_final got sysReady=%b busy=%b expected 1/0", bus.sysReady, bus.busy);
      end
      $display("test_sequence done");
   endtask

   task automatic test_timeout();
      do_reset(1'b0);
      block[2] = 1'b1;
      push_ev(3,  4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(6,  4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(9,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(17, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd2);
      run(25);
      finish_test("timeout");
      checks++;
      if (bus.fault !== 1'b1 || bus.faultStage !== 3'd2 || bus.sysReady !== 1'b0) begin
         errors++;
         $display("FAIL timeout_final got fault=%b fs=%0d sysReady=%b expected 1/2/0",
                  bus.fault, bus.faultStage, bus.sysReady);
      end
      $display("test_timeout done");
   endtask

   task automatic test_run_fault();
      do_reset(1'b0);
      push_seq();
      push_ev(19, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd1);
      run(18);
      block[1] = 1'b1;
      block[3] = 1'b1;
      bus.stageReady[1] = 1'b0;
      bus.stageReady[3] = 1'b0;
      run(6);
      finish_test("run_fault");
      $display("test_run_fault done");
   endtask

   task automatic test_soft_reset();
      do_reset(1'b0);
      push_ev(3,  4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(6,  4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(9,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(11, 4'b1111, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(14, 4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(17, 4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(20, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(23, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(26, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
      run(10);
      bus.softResetReq = 1'b1;
      run(1);
      bus.softResetReq = 1'b0;
      run(20);
      finish_test("soft_reset");
      $display("test_soft_reset done");
   endtask

   task automatic test_timeout_coincide();
      do_reset(1'b0);
      block[1] = 1'b1;
      push_ev(3,  4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(6,  4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(14, 4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(17, 4'b0000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(20, 4'b0000, 1'b1, 1'b0, 1'b0, 3'd0);
      run(13);
      bus.stageReady[1] = 1'b1;
      run(10);
      finish_test("timeout_coincide");
      $display("test_timeout_coincide done");
   endtask

   task automatic test_reset_in_fault();
      do_reset(1'b0);
      block[2] = 1'b1;
      push_ev(3,  4'b1110, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(6,  4'b1100, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(9,  4'b1000, 1'b0, 1'b1, 1'b0, 3'd0);
      push_ev(17, 4'b1111, 1'b0, 1'b0, 1'b1, 3'd2);
      run(20);
      finish_test("fault_entry");
      do_reset(1'b1);
      push_seq();
      run(20);
      finish_test("reset_in_fault");
      $display("test_reset_in_fault done");
   endtask

   initial begin
      bus.softResetReq = 1'b0;
      bus.stageReady   = '0;
      block            = '0;
      for (int s = 0; s < NS; s++) low_cnt[s] = 0;
      test_reset();
      test_sequence();
      test_timeout();
      test_run_fault();
      test_soft_reset();
      test_timeout_coincide();
      test_reset_in_fault();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
